// File: rtl/serial_cmp_n.sv
// serial_cmp_n: serial magnitude comparator over framed DIGIT_W-bit digit streams.
// Two operands arrive one digit per accepted beat. Running a-vs-b flags are
// updated on every beat, and a registered per-word result is produced with a
// one-cycle done pulse. All outputs are registered.
//
// Input framing: a beat on a/b is accepted on a rising clock edge when in_valid
// is high and either a word is already in progress (ACCUM) or start is high.
// There is no back-pressure, so every accepted beat is consumed immediately.
module serial_cmp_n #(
   parameter int DIGIT_W   = 1,
   parameter int WORD_LEN  = 8,
   parameter int MSB_FIRST = 0,
   parameter int SIGNED    = 0
) (
   input  logic               clk,
   input  logic               reset,     // asynchronous, active-low
   input  logic               start,
   input  logic               in_valid,
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   output logic               busy,
   output logic               alessb,
   output logic               aequalb,
   output logic               agreatb,
   output logic               done,
   output logic               res_lt,
   output logic               res_eq,
   output logic               res_gt,
   output logic               dbg_state  // 0 = IDLE, 1 = ACCUM
);

   localparam int CW = $clog2(WORD_LEN + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WORD_LEN);

   typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          res_lt_q, res_lt_d, res_eq_q, res_eq_d, res_gt_q, res_gt_d;

   logic [CW-1:0] pos;
   logic [CW-1:0] next_cnt;
   logic          is_msd;
   logic          dig_lt, dig_gt;
   logic          accept;
   logic          base_lt, base_gt;

   // Per-digit compare; the sign-carrying digit is compared as signed.
   always_comb begin
      pos      = start ? '0 : count_q;
      next_cnt = pos + CW'(1);
      if (MSB_FIRST != 0) begin
         is_msd = (pos == '0);
      end else begin
         is_msd = (pos == LAST_CNT - CW'(1));
      end
      if ((SIGNED != 0) && is_msd) begin
         dig_gt = $signed(a) > $signed(b);
         dig_lt = $signed(a) < $signed(b);
      end else begin
         dig_gt = a > b;
         dig_lt = a < b;
      end
   end

   // Next-state logic: decision update, beat counting and word completion.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      lt_d     = lt_q;
      gt_d     = gt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      res_lt_d = res_lt_q;
      res_eq_d = res_eq_q;
      res_gt_d = res_gt_q;
      accept   = in_valid & (start | (state_q == ACCUM));
      // A start beat begins from an "equal" decision, aborting any open word.
      base_lt  = start ? 1'b0 : lt_q;
      base_gt  = start ? 1'b0 : gt_q;

      if (accept) begin
         if (MSB_FIRST != 0) begin
            // Once a higher digit differs, the decision stays locked.
            if (!base_lt && !base_gt) begin
               lt_d = dig_lt;
               gt_d = dig_gt;
            end else begin
               lt_d = base_lt;
               gt_d = base_gt;
            end
         end else begin
            // Each more-significant differing digit overrides lower ones.
            if (dig_lt || dig_gt) begin
               lt_d = dig_lt;
               gt_d = dig_gt;
            end else begin
               lt_d = base_lt;
               gt_d = base_gt;
            end
         end

         if (next_cnt == LAST_CNT) begin
            state_d  = IDLE;
            count_d  = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            res_lt_d = lt_d;
            res_gt_d = gt_d;
            res_eq_d = ~lt_d & ~gt_d;
         end else begin
            state_d  = ACCUM;
            count_d  = next_cnt;
            busy_d   = 1'b1;
         end
      end
      eq_d = ~lt_d & ~gt_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         lt_q     <= 1'b0;
         gt_q     <= 1'b0;
         eq_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         res_lt_q <= 1'b0;
         res_eq_q <= 1'b0;
         res_gt_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         lt_q     <= lt_d;
         gt_q     <= gt_d;
         eq_q     <= eq_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         res_lt_q <= res_lt_d;
         res_eq_q <= res_eq_d;
         res_gt_q <= res_gt_d;
      end
   end

   assign busy      = busy_q;
   assign alessb    = lt_q;
   assign aequalb   = eq_q;
   assign agreatb   = gt_q;
   assign done      = done_q;
   assign res_lt    = res_lt_q;
   assign res_eq    = res_eq_q;
   assign res_gt    = res_gt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_cmp_n.sv
// Bench for serial_cmp_n: four configurations side by side, directed words,
// a scoreboard queue of tagged expected results popped on every done.
module tb_serial_cmp_n;

   // Instance 0: 1-bit, 8 digits, LSB-first, unsigned
   // Instance 1: 1-bit, 8 digits, MSB-first, signed
   // Instance 2: 1-bit, 8 digits, MSB-first, unsigned
   // Instance 3: 4-bit, 2 digits, LSB-first, unsigned
   localparam logic [2:0] F_LT = 3'b100;
   localparam logic [2:0] F_EQ = 3'b010;
   localparam logic [2:0] F_GT = 3'b001;

   logic       clk;
   logic       rst_n;
   logic       st_s[4];
   logic       iv_s[4];
   logic [3:0] a_s[4];
   logic [3:0] b_s[4];
   logic       busy_w[4], lt_w[4], eq_w[4], gt_w[4], done_w[4];
   logic       rlt_w[4], req_w[4], rgt_w[4], dbg_w[4];

   int checks;
   int failures;
   logic [4:0] exp_q[$];   // {instance id[1:0], lt, eq, gt}

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int DW  = (g == 3) ? 4 : 1;
      localparam int WL  = (g == 3) ? 2 : 8;
      localparam int MSB = (g == 1 || g == 2) ? 1 : 0;
      localparam int SGN = (g == 1) ? 1 : 0;
      serial_cmp_n #(.DIGIT_W(DW), .WORD_LEN(WL), .MSB_FIRST(MSB), .SIGNED(SGN)) u_dut (
         .clk      (clk),
         .reset    (rst_n),
         .start    (st_s[g]),
         .in_valid (iv_s[g]),
         .a        (a_s[g][DW-1:0]),
         .b        (b_s[g][DW-1:0]),
         .busy     (busy_w[g]),
         .alessb   (lt_w[g]),
         .aequalb  (eq_w[g]),
         .agreatb  (gt_w[g]),
         .done     (done_w[g]),
         .res_lt   (rlt_w[g]),
         .res_eq   (req_w[g]),
         .res_gt   (rgt_w[g]),
         .dbg_state(dbg_w[g])
      );
   end

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] flags(input int i);
      return {lt_w[i], eq_w[i], gt_w[i]};
   endfunction

   // monitor: every done pops one expected tagged result
   always @(negedge clk) begin
      logic [4:0] e;
      for (int i = 0; i < 4; i++) begin
         if (rst_n && done_w[i]) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: instance %0d got done with empty queue at %0t", i, $time);
            end else begin
               e = exp_q.pop_front();
               chk("done_instance", i, {30'd0, e[4:3]});
               chk("result", {29'd0, rlt_w[i], req_w[i], rgt_w[i]}, {29'd0, e[2:0]});
            end
         end
      end
   end

   // driver: put one digit on an instance's inputs
   task automatic drive_digit(input int id, input logic [31:0] av, input logic [31:0] bv,
                              input int k, input logic st);
      int dw, wl, j;
      logic [31:0] ta, tb;
      dw = (id == 3) ? 4 : 1;
      wl = (id == 3) ? 2 : 8;
      j  = (id == 1 || id == 2) ? (wl - 1 - k) : k;
      ta = av >> (j * dw);
      tb = bv >> (j * dw);
      iv_s[id] = 1'b1;
      st_s[id] = st;
      a_s[id]  = (dw == 4) ? ta[3:0] : {3'b000, ta[0]};
      b_s[id]  = (dw == 4) ? tb[3:0] : {3'b000, tb[0]};
   endtask

   // driver: send nb digits of a word; gap idle cycles follow the first beat
   task automatic send_word(input int id, input logic [31:0] av, input logic [31:0] bv,
                            input int nb, input int gap, input logic do_push,
                            input logic [2:0] res, input logic [2:0] f1, input logic [2:0] f_last);
      int wl;
      wl = (id == 3) ? 2 : 8;
      if (do_push) exp_q.push_back({id[1:0], res});
      for (int k = 0; k < nb; k++) begin
         drive_digit(id, av, bv, k, k == 0);
         @(negedge clk);
         iv_s[id] = 1'b0;
         st_s[id] = 1'b0;
         if (k == 0) begin
            chk("run_first", {29'd0, flags(id)}, {29'd0, f1});
            for (int g2 = 0; g2 < gap; g2++) begin
               @(negedge clk);
               chk("run_gap", {29'd0, flags(id)}, {29'd0, f1});
               chk("busy_gap", {31'd0, busy_w[id]}, 32'd1);
            end
         end
      end
      chk("run_last", {29'd0, flags(id)}, {29'd0, f_last});
      chk("busy_end", {31'd0, busy_w[id]}, (nb < wl) ? 32'd1 : 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_busy"},  {31'd0, busy_w[i]}, 32'd0);
         chk({tag, "_flags"}, {29'd0, flags(i)}, {29'd0, F_EQ});
         chk({tag, "_done"},  {31'd0, done_w[i]}, 32'd0);
         chk({tag, "_res"},   {29'd0, rlt_w[i], req_w[i], rgt_w[i]}, 32'd0);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         st_s[i] = 1'b0;
         iv_s[i] = 1'b0;
         a_s[i]  = 4'd0;
         b_s[i]  = 4'd0;
      end
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // LSB-first unsigned
      send_word(0, 32'hA5, 32'hA4, 8, 0, 1'b1, F_GT, F_GT, F_GT);
      send_word(0, 32'h01, 32'h80, 8, 0, 1'b1, F_LT, F_GT, F_LT);
      send_word(0, 32'h3C, 32'h3C, 8, 0, 1'b1, F_EQ, F_EQ, F_EQ);
      // MSB-first: signed sees -128 < 127, unsigned sees 128 > 127
      send_word(1, 32'h80, 32'h7F, 8, 0, 1'b1, F_LT, F_LT, F_LT);
      send_word(2, 32'h80, 32'h7F, 8, 0, 1'b1, F_GT, F_GT, F_GT);
      send_word(1, 32'h05, 32'h03, 8, 0, 1'b1, F_GT, F_EQ, F_GT);
      // 4-bit digits with idle gaps between beats
      send_word(3, 32'h3C, 32'h4B, 2, 3, 1'b1, F_LT, F_GT, F_LT);
      // abort: 3 beats, then a fresh start with new operands
      send_word(0, 32'hFF, 32'h00, 3, 0, 1'b0, F_EQ, F_GT, F_GT);
      send_word(0, 32'h00, 32'h02, 8, 0, 1'b1, F_LT, F_EQ, F_LT);

      // reset mid-word after 5 beats
      send_word(0, 32'hFF, 32'h00, 5, 0, 1'b0, F_EQ, F_GT, F_GT);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      // non-start beats in IDLE are ignored
      iv_s[0] = 1'b1; st_s[0] = 1'b0; a_s[0] = 4'd1; b_s[0] = 4'd0;
      repeat (3) @(negedge clk);
      iv_s[0] = 1'b0;
      chk("ignored_busy", {31'd0, busy_w[0]}, 32'd0);
      chk("ignored_flags", {29'd0, flags(0)}, {29'd0, F_EQ});
      chk("ignored_state", {31'd0, dbg_w[0]}, 32'd0);

      // back-to-back words on the 2-digit instance
      exp_q.push_back({2'd3, F_GT});
      exp_q.push_back({2'd3, F_EQ});
      drive_digit(3, 32'h12, 32'h11, 0, 1'b1);
      @(negedge clk);
      drive_digit(3, 32'h12, 32'h11, 1, 1'b0);
      @(negedge clk);
      drive_digit(3, 32'h55, 32'h55, 0, 1'b1);
      @(negedge clk);
      chk("b2b_new_word_flags", {29'd0, flags(3)}, {29'd0, F_EQ});
      chk("b2b_busy", {31'd0, busy_w[3]}, 32'd1);
      drive_digit(3, 32'h55, 32'h55, 1, 1'b0);
      @(negedge clk);
      iv_s[3] = 1'b0;
      st_s[3] = 1'b0;
      repeat (4) @(negedge clk);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
